// File: rtl/fft_pkg.sv
// Shared helpers for the FFT datapath: frame-length derivation and index bit reversal.
package fft_pkg;

    localparam int unsigned MAX_N = 12;

    function automatic int unsigned frame_len(input int unsigned n);
        return 32'd1 << n;
    endfunction

    // Reverses the low n bits of k; bits at and above n come back as zero.
    function automatic logic [MAX_N-1:0] bit_rev(input logic [MAX_N-1:0] k, input int unsigned n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < int'(n)) begin
                r[i] = k[int'(n) - 1 - i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bitrev_idx.sv
// Combinational N-bit index reversal used to address the read bank.
module bitrev_idx
    import fft_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0] idx_i,
    output logic [N-1:0] rev_o
);

    assign rev_o = N'(bit_rev(MAX_N'(idx_i), N));

endmodule

// File: rtl/bitrev_reorder_buf.sv
// Ping-pong frame buffer: natural-order samples in, bit-reversed order out.
// Optional macro BITREV_BYPASS_EN adds a per-frame natural-order read mode.
module bitrev_reorder_buf
    import fft_pkg::*;
#(
    parameter int N  = 3,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
`ifdef BITREV_BYPASS_EN
    input  logic          bypass,
`endif
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    localparam int FRAME = int'(frame_len(N));
    localparam logic [N-1:0] LAST = '1;

    logic [DW-1:0] mem_q [2][FRAME];
    logic [1:0]    full_q, full_d;
    logic          wb_q, wb_d;
    logic          rb_q, rb_d;
    logic [N-1:0]  wcnt_q, wcnt_d;
    logic [N-1:0]  rcnt_q, rcnt_d;

    logic          in_fire, out_fire;
    logic          wr_done, rd_done;
    logic [N-1:0]  rev_idx, rd_idx;

    assign in_ready  = !full_q[wb_q];
    assign out_valid = full_q[rb_q];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign wr_done   = in_fire && (wcnt_q == LAST);
    assign rd_done   = out_fire && (rcnt_q == LAST);

    // Write and read banks are always distinct when both events fire, so the
    // two flag updates never collide.
    always_comb begin
        full_d = full_q;
        wb_d   = wb_q ^ wr_done;
        rb_d   = rb_q ^ rd_done;
        wcnt_d = in_fire ? wcnt_q + 1'b1 : wcnt_q;
        rcnt_d = out_fire ? rcnt_q + 1'b1 : rcnt_q;
        if (wr_done) begin
            full_d[wb_q] = 1'b1;
        end
        if (rd_done) begin
            full_d[rb_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= '0;
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            wcnt_q <= '0;
            rcnt_q <= '0;
        end else begin
            full_q <= full_d;
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
        end
    end

    // Sample storage is not reset; full flags gate every read.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_q[wb_q][wcnt_q] <= in_data;
        end
    end

    bitrev_idx #(
        .N(N)
    ) u_bitrev_idx (
        .idx_i(rcnt_q),
        .rev_o(rev_idx)
    );

`ifdef BITREV_BYPASS_EN
    logic [1:0] mode_q, mode_d;

    // Mode is captured with the first sample of a frame and travels with its bank.
    always_comb begin
        mode_d = mode_q;
        if (in_fire && (wcnt_q == '0)) begin
            mode_d[wb_q] = bypass;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= '0;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign rd_idx = mode_q[rb_q] ? rcnt_q : rev_idx;
`else
    assign rd_idx = rev_idx;
`endif

    assign out_data = mem_q[rb_q][rd_idx];
    assign out_last = out_valid && (rcnt_q == LAST);

endmodule

// File: tb/tb_bitrev_reorder_buf.sv
// Directed bench for bitrev_reorder_buf: N=3 instance with scoreboard, plus an N=1 instance.
module tb_bitrev_reorder_buf;

    localparam int N  = 3;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
`ifdef BITREV_BYPASS_EN
    logic          bypass;
    logic          bypass1;
`endif

    logic          in_valid1;
    logic          in_ready1;
    logic [7:0]    in_data1;
    logic          out_valid1;
    logic          out_ready1;
    logic [7:0]    out_data1;
    logic          out_last1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bitrev_reorder_buf #(.N(N), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef BITREV_BYPASS_EN
        .bypass   (bypass),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    bitrev_reorder_buf #(.N(1), .DW(8)) dut1 (
        .clk      (clk),
        .rst      (rst),
`ifdef BITREV_BYPASS_EN
        .bypass   (bypass1),
`endif
        .in_valid (in_valid1),
        .in_ready (in_ready1),
        .in_data  (in_data1),
        .out_valid(out_valid1),
        .out_ready(out_ready1),
        .out_data (out_data1),
        .out_last (out_last1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [DW-1:0] exp_q[$];
    logic          exp_last_q[$];
    int            hs_cyc[$];
    int            rev3[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Scoreboard: every output handshake must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("out_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                check("out_last", 32'(out_last), 32'(exp_last_q.pop_front()));
                hs_cyc.push_back(cyc);
            end
        end
    end

    task automatic do_reset();
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b0;
        in_valid1  = 1'b0;
        in_data1   = '0;
        out_ready1 = 1'b0;
`ifdef BITREV_BYPASS_EN
        bypass  = 1'b0;
        bypass1 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_last_q.delete();
        hs_cyc.delete();
    endtask

    // Called just after a rising edge; returns just after the edge that accepts d.
    task automatic send(input logic [DW-1:0] d);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("send_timeout", 32'(t), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int base, input bit natural);
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(DW'(base + (natural ? k : rev3[k])));
            exp_last_q.push_back(k == 7);
        end
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int t;

        // Reset state.
        do_reset();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_in_ready1", 32'(in_ready1), 32'd1);
        check("rst_out_valid1", 32'(out_valid1), 32'd0);

        // Single frame, bit-reversed output and one-cycle latency.
        out_ready = 1'b1;
        push_frame(0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("lat_before", 32'(out_valid), 32'd0);
            send(DW'(i));
        end
        in_valid = 1'b0;
        check("lat_after", 32'(out_valid), 32'd1);
        wait_drain("drain_single");

        // Three continuous frames, no bubbles on either side.
        do_reset();
        out_ready = 1'b1;
        push_frame(0, 1'b0);
        push_frame(8, 1'b0);
        push_frame(16, 1'b0);
        t = cyc;
        for (int i = 0; i < 24; i++) send(DW'(i));
        in_valid = 1'b0;
        check("in_no_bubble", 32'(cyc - t), 32'd24);
        wait_drain("drain_three");
        check("out_count", 32'(hs_cyc.size()), 32'd24);
        if (hs_cyc.size() == 24) check("out_no_bubble", 32'(hs_cyc[23] - hs_cyc[0]), 32'd23);

        // Backpressure: both banks fill, data held, then drain in order.
        do_reset();
        push_frame(0, 1'b0);
        push_frame(8, 1'b0);
        push_frame(16, 1'b0);
        for (int i = 0; i < 16; i++) send(DW'(i));
        check("full_in_ready", 32'(in_ready), 32'd0);
        fork
            begin
                for (int i = 16; i < 24; i++) send(DW'(i));
                in_valid = 1'b0;
            end
            begin
                int w;
                repeat (4) begin
                    @(negedge clk);
                    check("hold_valid", 32'(out_valid), 32'd1);
                    check("hold_data", 32'(out_data), 32'd0);
                    check("hold_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                w = 0;
                @(negedge clk);
                while (!in_ready && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                check("rise_seen", 32'(hs_cyc.size() >= 8), 32'd1);
                if (hs_cyc.size() >= 8) check("in_ready_rise", 32'(cyc), 32'(hs_cyc[7] + 1));
            end
        join
        wait_drain("drain_bp");

        // Reset mid-frame discards the partial frame.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(DW'(50 + i));
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        push_frame(100, 1'b0);
        for (int i = 0; i < 8; i++) send(DW'(100 + i));
        in_valid = 1'b0;
        wait_drain("drain_midrst");

`ifdef BITREV_BYPASS_EN
        // Natural-order frame followed by a reversed frame.
        do_reset();
        out_ready = 1'b1;
        push_frame(0, 1'b1);
        push_frame(8, 1'b0);
        bypass = 1'b1;
        for (int i = 0; i < 8; i++) send(DW'(i));
        bypass = 1'b0;
        for (int i = 8; i < 16; i++) send(DW'(i));
        in_valid = 1'b0;
        wait_drain("drain_bypass");
`endif

        // N=1: single-bit reversal is the identity.
        do_reset();
        out_ready1 = 1'b1;
        in_valid1  = 1'b1;
        in_data1   = 8'h0A;
        @(posedge clk);
        #1;
        in_data1 = 8'h0B;
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        check("n1_valid", 32'(out_valid1), 32'd1);
        check("n1_data0", 32'(out_data1), 32'h0A);
        check("n1_last0", 32'(out_last1), 32'd0);
        @(posedge clk);
        #1;
        check("n1_data1", 32'(out_data1), 32'h0B);
        check("n1_last1", 32'(out_last1), 32'd1);
        @(posedge clk);
        #1;
        check("n1_empty", 32'(out_valid1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bitrev_reorder_buf.md
BITREV_REORDER_BUF -- requirements
Module: bitrev_reorder_buf

Interface
REQ-001 Parameter: N, default 3, log2 of frame length (frame = 2^N samples); legal range 1..12.
REQ-002 Parameter: DW, default 16, sample data width in bits.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  input sample present.
REQ-006 Port: in_ready  output  1  block can accept input sample.
REQ-007 Port: in_data  input  DW  input sample, natural order.
REQ-008 Port: out_valid  output  1  output sample present.
REQ-009 Port: out_ready  input  1  downstream accepts output sample.
REQ-010 Port: out_data  output  DW  output sample, reordered.
REQ-011 Port: out_last  output  1  high with final sample of each output frame.
REQ-012 Port: bypass  input  1  natural-order mode request; present only when BITREV_BYPASS_EN is defined.

Function
REQ-013 Storage: two banks (ping-pong), each 2^N x DW; per-bank full flag; write-bank select wb, read-bank select rb; N-bit write counter wcnt, N-bit read counter rcnt.
REQ-014 Transfer occurs on a handshake only: input on in_valid&&in_ready, output on out_valid&&out_ready.
REQ-015 in_ready = !full[wb]; out_valid = full[rb]; both combinational from registered state.
REQ-016 Input transfer writes bank[wb][wcnt] and increments wcnt; at wcnt==2^N-1 it sets full[wb], toggles wb, wraps wcnt to 0.
REQ-017 out_data = bank[rb][rev(rcnt)], where rev(k) bit i = k bit N-1-i; combinational read.
REQ-018 Output transfer increments rcnt; at rcnt==2^N-1 it clears full[rb], toggles rb, wraps rcnt to 0.
REQ-019 out_last = out_valid && (rcnt==2^N-1).
REQ-020 Latency: out_valid rises the cycle after the last input sample of a frame is accepted.
REQ-021 Throughput: with out_ready held high and in_valid held high, one sample per cycle in each direction, no bubbles between frames.
REQ-022 Simultaneous frame-complete on write bank and frame-drain on read bank in one cycle: both flag updates apply; never the same bank.
REQ-023 Both banks full: in_ready low until the read bank drains its last sample; in_ready rises the following cycle.
REQ-024 out_valid held and out_data stable while out_ready low.

Reset
REQ-025 rst clears full[1:0], wb, rb, wcnt, rcnt; outputs after reset: in_ready=1, out_valid=0, out_last=0.
REQ-026 rst mid-frame discards any partial or unread frame; bank contents are not reset and are never observable before being rewritten.

Configuration
REQ-027 Macro BITREV_BYPASS_EN defined: bypass port exists; its value is sampled with the first accepted sample of each frame (wcnt==0) into a per-bank mode bit; a bank with mode bit set is read in natural order (out_data = bank[rb][rcnt]); mode bits cleared by rst.
REQ-028 Macro BITREV_BYPASS_EN undefined: no bypass port, no mode bits; output always bit-reversed.

Structure
REQ-029 Shared package fft_pkg holds the bit-reverse function and the frame-length constant derivation (1<<N); used by all FFT blocks.
REQ-030 One sub-module is natural: bitrev_idx (parameter N, combinational N-bit reversal of rcnt).

Verification
REQ-031 N=3, input 0..7 back-to-back, out_ready=1 -> output 0,4,2,6,1,5,3,7; out_last on 7; first out_valid one cycle after input 7 accepted.
REQ-032 N=3, three frames (0..7, 8..15, 16..23) continuous, out_ready=1 -> 24 outputs, no bubbles, frame 2 = 8,12,10,14,9,13,11,15.
REQ-033 out_ready=0 for 20 cycles while feeding 0..23 -> in_ready drops after 16 samples; on out_ready=1, frames drain in order; in_ready rises the cycle after output 7's handshake.
REQ-034 rst asserted after 5 input samples of a frame -> in_ready=1, out_valid=0 next cycle; new frame 100..107 outputs 100,104,102,106,101,105,103,107.
REQ-035 BITREV_BYPASS_EN, frame 0..7 with bypass=1, then 8..15 with bypass=0 -> 0..7 in natural order, then 8,12,10,14,9,13,11,15.
REQ-036 N=1, DW=8, input 0xA,0xB -> output 0xA,0xB (reversal of 1 bit is identity); out_last on 0xB.
